dm_abstract_ctrl: RTL and testbench
===================================

DM_ABSTRACT_CTRL -- requirements
Module: dm_abstract_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max REG cycles awaiting reg_ack before abort (0 = no timeout).
REQ-002 SHALL have parameter XLEN, default 32, data0/register width; only 32 supported.
REQ-003 SHALL use a single clock clk; reset rst is synchronous, active-high.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 cmd_valid  in  1  DMI write strobe to command register.
REQ-007 cmd  in  32  command word: cmdtype[31:24], control[23:0].
REQ-008 cmderr_clr  in  3  write-1-to-clear mask for cmderr.
REQ-009 data0_we / data0_wdata  in  1 / 32  DMI write of data0.
REQ-010 hart_halted  in  1  hart halted status.
REQ-011 reg_req / reg_we / reg_addr / reg_wdata  out  1/1/16/32  register access request to hart.
REQ-012 reg_ack / reg_err / reg_rdata  in  1/1/32  hart completion, exception flag, read data.
REQ-013 busy / cmderr / data0 / regno  out  1/3/32/16  abstractcs.busy, abstractcs.cmderr, data0, latched regno.

Function
REQ-014 SHALL decode control as aarsize[22:20], aarpostincrement[19], postexec[18], transfer[17], write[16], regno[15:0].
REQ-015 SHALL implement states IDLE, REG, DONE; busy=1 in REG and DONE only.
REQ-016 IDLE, cmd_valid, cmderr!=0 (pre-clear value): command ignored, no state change.
REQ-017 IDLE, cmd_valid, cmderr==0: cmdtype!=0, postexec=1, or transfer=1 with aarsize!=2 -> cmderr=2, stay IDLE.
REQ-018 IDLE, cmd_valid, valid command, hart_halted=0 -> cmderr=4, stay IDLE.
REQ-019 Valid command, halted, transfer=1: latch write/regno, next cycle REG with reg_req=1, reg_we=write, reg_addr=regno, reg_wdata=data0.
REQ-020 Valid command, transfer=0: next cycle DONE (busy high exactly one cycle), then IDLE.
REQ-021 REG: request outputs held stable until reg_ack; reg_req drops the cycle after reg_ack.
REQ-022 reg_ack with reg_err=0, write=0: data0<=reg_rdata; state IDLE next cycle; busy low one cycle after ack.
REQ-023 reg_ack with reg_err=1: data0 unchanged, cmderr=3, IDLE.
REQ-024 REG timeout: TIMEOUT cycles elapsed without reg_ack -> reg_req drops, cmderr=3, IDLE; counter cleared on every REG entry.
REQ-025 hart_halted falls during REG before ack: abort, reg_req drops, cmderr=4, DONE then IDLE.
REQ-026 cmd_valid or data0_we while busy: write ignored; cmderr=1 if cmderr==0.
REQ-027 data0_we while not busy: data0<=data0_wdata next cycle.
REQ-028 cmderr bits clear where cmderr_clr=1; new error in same cycle wins over clear.
REQ-029 cmderr, once nonzero, SHALL change only via cmderr_clr or reset.

Reset
REQ-030 rst SHALL force state IDLE, busy=0, cmderr=0, data0=0, regno=0, reg_req=0, reg_we=0, reg_addr=0, reg_wdata=0, timeout counter 0.
REQ-031 rst asserted mid-REG SHALL drop reg_req the following cycle; a subsequent reg_ack SHALL be ignored.

Configuration
REQ-032 Macro DM_POSTINCREMENT_EN defined: after successful transfer (REQ-022 path, write or read), regno increments by 1, wrapping 0xFFFF->0x0000; not on error/abort.
REQ-033 Macro DM_POSTINCREMENT_EN undefined: aarpostincrement=1 treated as unsupported, cmderr=2, no access.

Verification
REQ-034 Halted, cmd=0x00221000 (read regno 0x1000), reg_ack with rdata=0xDEADBEEF after 3 cycles -> reg_req 3 cycles, data0=0xDEADBEEF, busy low, cmderr=0.
REQ-035 Halted, data0=0x12345678, cmd=0x00231001 -> reg_we=1, reg_addr=0x1001, reg_wdata=0x12345678; second cmd_valid mid-REG -> cmderr=1, first access completes.
REQ-036 Not halted, cmd=0x00221000 -> cmderr=4, reg_req never asserts; cmderr_clr=3'b111 -> cmderr=0.
REQ-037 cmd=0x01000000 -> cmderr=2; cmd=0x00321000 (aarsize 3) -> unchanged cmderr=2 (ignored); TIMEOUT=4, no ack -> cmderr=3 after 4 REG cycles.
REQ-038 DM_POSTINCREMENT_EN, cmd=0x002AFFFF, ack -> regno=0x0000; without macro -> cmderr=2, no reg_req.

Source files
------------

// File: rtl/dm_abstract_ctrl.sv
// rtl/dm_abstract_ctrl.sv - debug-module abstract command controller (register access only).
// Optional feature: define DM_POSTINCREMENT_EN to honour aarpostincrement on register transfers.
module dm_abstract_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  input  logic [31:0]     cmd,
  input  logic [2:0]      cmderr_clr,
  input  logic            data0_we,
  input  logic [XLEN-1:0] data0_wdata,
  input  logic            hart_halted,
  output logic            reg_req,
  output logic            reg_we,
  output logic [15:0]     reg_addr,
  output logic [XLEN-1:0] reg_wdata,
  input  logic            reg_ack,
  input  logic            reg_err,
  input  logic [XLEN-1:0] reg_rdata,
  output logic            busy,
  output logic [2:0]      cmderr,
  output logic [XLEN-1:0] data0,
  output logic [15:0]     regno
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REG  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [31:0] tcnt;

  logic [7:0]  cmdtype;
  logic [2:0]  aarsize;
  logic        postinc;
  logic        postexec;
  logic        transfer;
  logic        wr;
  logic [15:0] cmd_regno;
  logic        ctl_unused;

  assign cmdtype    = cmd[31:24];
  assign ctl_unused = cmd[23];
  assign aarsize    = cmd[22:20];
  assign postinc    = cmd[19];
  assign postexec   = cmd[18];
  assign transfer   = cmd[17];
  assign wr         = cmd[16];
  assign cmd_regno  = cmd[15:0];

  assign busy = (state != S_IDLE);

  logic       cmd_bad;
  logic       timeout_hit;
  logic       err_ev;
  logic [2:0] err_code;
  logic [2:0] cleared;

`ifdef DM_POSTINCREMENT_EN
  logic postinc_q;
  assign cmd_bad = (cmdtype != 8'd0) || postexec || (transfer && aarsize != 3'd2);
`else
  assign cmd_bad = (cmdtype != 8'd0) || postexec || (transfer && aarsize != 3'd2) || postinc;
`endif

  assign timeout_hit = (TIMEOUT != 0) && (tcnt == 32'(TIMEOUT - 1));
  assign cleared     = cmderr & ~cmderr_clr;

  always_comb begin
    err_ev   = 1'b0;
    err_code = 3'd0;
    case (state)
      S_IDLE: begin
        if (cmd_valid && cmderr == 3'd0) begin
          if (cmd_bad) begin
            err_ev   = 1'b1;
            err_code = 3'd2;
          end else if (!hart_halted) begin
            err_ev   = 1'b1;
            err_code = 3'd4;
          end
        end
      end
      S_REG: begin
        if (reg_ack) begin
          if (reg_err) begin
            err_ev   = 1'b1;
            err_code = 3'd3;
          end
        end else if (!hart_halted) begin
          err_ev   = 1'b1;
          err_code = 3'd4;
        end else if (timeout_hit) begin
          err_ev   = 1'b1;
          err_code = 3'd3;
        end
      end
      default: ;
    endcase
    // A host write that collides with a running command is the lowest-priority error.
    if (!err_ev && busy && (cmd_valid || data0_we)) begin
      err_ev   = 1'b1;
      err_code = 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tcnt      <= 32'd0;
      cmderr    <= 3'd0;
      data0     <= '0;
      regno     <= 16'd0;
      reg_req   <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= 16'd0;
      reg_wdata <= '0;
`ifdef DM_POSTINCREMENT_EN
      postinc_q <= 1'b0;
`endif
    end else begin
      // An error only lands on a zero (possibly just-cleared) cmderr, so it beats a same-cycle clear.
      cmderr <= (err_ev && cleared == 3'd0) ? err_code : cleared;
      case (state)
        S_IDLE: begin
          if (data0_we) data0 <= data0_wdata;
          if (cmd_valid && cmderr == 3'd0 && !cmd_bad && hart_halted) begin
            if (transfer) begin
              state     <= S_REG;
              tcnt      <= 32'd0;
              reg_req   <= 1'b1;
              reg_we    <= wr;
              reg_addr  <= cmd_regno;
              reg_wdata <= data0;
              regno     <= cmd_regno;
`ifdef DM_POSTINCREMENT_EN
              postinc_q <= postinc;
`endif
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_REG: begin
          if (reg_ack) begin
            reg_req <= 1'b0;
            state   <= S_IDLE;
            if (!reg_err) begin
              if (!reg_we) data0 <= reg_rdata;
`ifdef DM_POSTINCREMENT_EN
              if (postinc_q) regno <= regno + 16'd1;
`endif
            end
          end else if (!hart_halted) begin
            reg_req <= 1'b0;
            state   <= S_DONE;
          end else if (timeout_hit) begin
            reg_req <= 1'b0;
            state   <= S_IDLE;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_abstract_ctrl.sv
// tb/tb_dm_abstract_ctrl.sv - self-checking bench for dm_abstract_ctrl (TIMEOUT=4).
module tb_dm_abstract_ctrl;

  localparam int TMO = 4;
`ifdef DM_POSTINCREMENT_EN
  localparam bit POSTINC = 1'b1;
`else
  localparam bit POSTINC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [31:0] cmd;
  logic [2:0]  cmderr_clr;
  logic        data0_we;
  logic [31:0] data0_wdata;
  logic        hart_halted;
  logic        reg_req, reg_we;
  logic [15:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_ack, reg_err;
  logic [31:0] reg_rdata;
  logic        busy;
  logic [2:0]  cmderr;
  logic [31:0] data0;
  logic [15:0] regno;

  dm_abstract_ctrl #(.TIMEOUT(TMO), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmderr_clr(cmderr_clr),
    .data0_we(data0_we), .data0_wdata(data0_wdata), .hart_halted(hart_halted),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_ack(reg_ack), .reg_err(reg_err), .reg_rdata(reg_rdata),
    .busy(busy), .cmderr(cmderr), .data0(data0), .regno(regno)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int req_cycles  = 0;
  int busy_cycles = 0;

  // Command-level model: an access is either in flight, in its one-cycle wrap-up, or absent.
  bit          m_in_reg = 0, m_done = 0, m_req = 0, m_we = 0, m_pinc = 0;
  logic [15:0] m_addr = 0, m_regno = 0;
  logic [31:0] m_wdata = 0, m_data0 = 0;
  logic [2:0]  m_cmderr = 0;
  int          m_elapsed = 0;

  bit          n_in_reg, n_done, n_req, n_we, n_pinc, legal, m_busy;
  logic [15:0] n_addr, n_regno;
  logic [31:0] n_wdata, n_data0;
  logic [2:0]  newerr, cl;

  always @(posedge clk) begin
    if (rst) begin
      m_in_reg = 0; m_done = 0; m_req = 0; m_we = 0; m_pinc = 0;
      m_addr = 0; m_regno = 0; m_wdata = 0; m_data0 = 0; m_cmderr = 0; m_elapsed = 0;
    end else begin
      n_in_reg = m_in_reg; n_done = m_done; n_req = m_req; n_we = m_we; n_pinc = m_pinc;
      n_addr = m_addr; n_regno = m_regno; n_wdata = m_wdata; n_data0 = m_data0;
      newerr = 0;
      m_busy = m_in_reg || m_done;
      cl = m_cmderr & ~cmderr_clr;
      if (!m_busy) begin
        if (cmd_valid && m_cmderr == 0) begin
          legal = (cmd[31:24] == 0) && !cmd[18] && !(cmd[17] && cmd[22:20] != 3'd2)
                  && (POSTINC || !cmd[19]);
          if (!legal) newerr = 2;
          else if (!hart_halted) newerr = 4;
          else if (cmd[17]) begin
            n_in_reg = 1; n_req = 1; n_we = cmd[16]; n_addr = cmd[15:0];
            n_wdata = m_data0; n_regno = cmd[15:0]; n_pinc = cmd[19]; m_elapsed = 0;
          end else n_done = 1;
        end
        if (data0_we) n_data0 = data0_wdata;
      end else if (m_in_reg) begin
        m_elapsed++;
        if (reg_ack) begin
          n_in_reg = 0; n_req = 0;
          if (reg_err) newerr = 3;
          else begin
            if (!m_we) n_data0 = reg_rdata;
            if (POSTINC && m_pinc) n_regno = m_regno + 16'd1;
          end
        end else if (!hart_halted) begin
          newerr = 4; n_in_reg = 0; n_req = 0; n_done = 1;
        end else if (TMO != 0 && m_elapsed == TMO) begin
          newerr = 3; n_in_reg = 0; n_req = 0;
        end
      end else n_done = 0;
      if (m_busy && (cmd_valid || data0_we) && newerr == 0) newerr = 1;
      m_cmderr = (newerr != 0 && cl == 0) ? newerr : cl;
      m_in_reg = n_in_reg; m_done = n_done; m_req = n_req; m_we = n_we; m_pinc = n_pinc;
      m_addr = n_addr; m_regno = n_regno; m_wdata = n_wdata; m_data0 = n_data0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reg_req === 1'b1) req_cycles++;
    if (busy === 1'b1) busy_cycles++;
    if (chk_en) begin
      chk("reg_req", {31'd0, reg_req}, {31'd0, m_req});
      chk("busy", {31'd0, busy}, {31'd0, m_in_reg || m_done});
      chk("cmderr", {29'd0, cmderr}, {29'd0, m_cmderr});
      chk("data0", data0, m_data0);
      chk("regno", {16'd0, regno}, {16'd0, m_regno});
      if (m_req) begin
        chk("reg_we", {31'd0, reg_we}, {31'd0, m_we});
        chk("reg_addr", {16'd0, reg_addr}, {16'd0, m_addr});
        chk("reg_wdata", reg_wdata, m_wdata);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] dv, input logic [31:0] mv,
                     input logic [31:0] ev);
    chk({name, "_dut"}, dv, ev);
    chk({name, "_model"}, mv, ev);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] c);
    cmd_valid = 1; cmd = c;
    step();
    cmd_valid = 0;
  endtask

  task automatic ack_after(input int n, input logic [31:0] rd, input logic er);
    repeat (n - 1) step();
    reg_ack = 1; reg_rdata = rd; reg_err = er;
    step();
    reg_ack = 0; reg_err = 0;
  endtask

  task automatic clear_err();
    cmderr_clr = 3'b111;
    step();
    cmderr_clr = 3'b000;
  endtask

  initial begin
    rst = 1; cmd_valid = 0; cmd = 0; cmderr_clr = 0; data0_we = 0; data0_wdata = 0;
    hart_halted = 1; reg_ack = 0; reg_err = 0; reg_rdata = 0;
    step(); step();
    rst = 0;
    chk_en = 1;
    lit("rst_busy", {31'd0, busy}, {31'd0, m_in_reg || m_done}, 0);
    lit("rst_cmderr", {29'd0, cmderr}, {29'd0, m_cmderr}, 0);
    lit("rst_data0", data0, m_data0, 0);

    // Read with ack in the third request cycle
    req_cycles = 0;
    issue(32'h0022_1000);
    lit("rd_addr", {16'd0, reg_addr}, {16'd0, m_addr}, 32'h1000);
    ack_after(3, 32'hDEAD_BEEF, 0);
    step();
    chk("rd_req_cycles", req_cycles, 3);
    lit("rd_data0", data0, m_data0, 32'hDEAD_BEEF);
    lit("rd_busy", {31'd0, busy}, {31'd0, m_in_reg || m_done}, 0);
    lit("rd_cmderr", {29'd0, cmderr}, {29'd0, m_cmderr}, 0);

    // Write, with a colliding command mid-access
    data0_we = 1; data0_wdata = 32'h1234_5678;
    step();
    data0_we = 0;
    issue(32'h0023_1001);
    lit("wr_we", {31'd0, reg_we}, {31'd0, m_we}, 1);
    lit("wr_addr", {16'd0, reg_addr}, {16'd0, m_addr}, 32'h1001);
    lit("wr_wdata", reg_wdata, m_wdata, 32'h1234_5678);
    issue(32'h0022_1000);
    ack_after(2, 32'h0BAD_0BAD, 0);
    step();
    lit("wr_cmderr", {29'd0, cmderr}, {29'd0, m_cmderr}, 1);
    lit("wr_data0", data0, m_data0, 32'h1234_5678);
    clear_err();

    // Not halted
    hart_halted = 0; req_cycles = 0;
    issue(32'h0022_1000);
    step();
    lit("nh_cmderr", {29'd0, cmderr}, {29'd0, m_cmderr}, 4);
    chk("nh_req_cycles", req_cycles, 0);
    clear_err();
    lit("nh_clr", {29'd0, cmderr}, {29'd0, m_cmderr}, 0);
    hart_halted = 1;

    // Unsupported commands, then timeout
    issue(32'h0100_0000);
    lit("bad_type", {29'd0, cmderr}, {29'd0, m_cmderr}, 2);
    issue(32'h0032_1000);
    lit("bad_size_ign", {29'd0, cmderr}, {29'd0, m_cmderr}, 2);
    clear_err();
    req_cycles = 0;
    issue(32'h0022_1000);
    repeat (6) step();
    chk("tmo_req_cycles", req_cycles, 4);
    lit("tmo_cmderr", {29'd0, cmderr}, {29'd0, m_cmderr}, 3);
    clear_err();

    // Post-increment at the top of the register space
    req_cycles = 0;
    issue(32'h002A_FFFF);
    if (POSTINC) begin
      ack_after(1, 32'hCAFE_0000, 0);
      step();
      lit("pi_regno", {16'd0, regno}, {16'd0, m_regno}, 0);
      lit("pi_data0", data0, m_data0, 32'hCAFE_0000);
    end else begin
      step();
      lit("pi_cmderr", {29'd0, cmderr}, {29'd0, m_cmderr}, 2);
      chk("pi_req_cycles", req_cycles, 0);
    end
    clear_err();

    // Hart reports an exception
    data0_we = 1; data0_wdata = 32'hA5A5_0001;
    step();
    data0_we = 0;
    issue(32'h0022_0010);
    ack_after(2, 32'hFFFF_FFFF, 1);
    lit("er_data0", data0, m_data0, 32'hA5A5_0001);
    lit("er_cmderr", {29'd0, cmderr}, {29'd0, m_cmderr}, 3);
    clear_err();

    // Hart resumes mid-access
    issue(32'h0022_0020);
    hart_halted = 0;
    step();
    lit("hf_busy", {31'd0, busy}, {31'd0, m_in_reg || m_done}, 1);
    lit("hf_cmderr", {29'd0, cmderr}, {29'd0, m_cmderr}, 4);
    step();
    lit("hf_idle", {31'd0, busy}, {31'd0, m_in_reg || m_done}, 0);
    hart_halted = 1;
    clear_err();

    // No-transfer command keeps busy for exactly one cycle
    busy_cycles = 0;
    issue(32'h0000_0000);
    repeat (3) step();
    chk("nt_busy_cycles", busy_cycles, 1);

    // data0 write while busy is dropped
    issue(32'h0022_0030);
    data0_we = 1; data0_wdata = 32'h0000_0055;
    step();
    data0_we = 0;
    ack_after(1, 32'h0000_0077, 0);
    lit("bw_data0", data0, m_data0, 32'h77);
    lit("bw_cmderr", {29'd0, cmderr}, {29'd0, m_cmderr}, 1);
    clear_err();

    // Reset mid-access, late ack ignored
    issue(32'h0022_0040);
    rst = 1;
    step();
    rst = 0;
    lit("rr_req", {31'd0, reg_req}, {31'd0, m_req}, 0);
    reg_ack = 1; reg_rdata = 32'h1111_2222;
    step();
    reg_ack = 0;
    step();
    lit("rr_data0", data0, m_data0, 0);
    lit("rr_busy", {31'd0, busy}, {31'd0, m_in_reg || m_done}, 0);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
